// File: rtl/pan_pkg.sv
// Shared definitions for the PAN digit serializer: length limits, widths
// and the FSM state encoding.
package pan_pkg;

  localparam int MAX_LEN_DEF = 19;
  localparam int MIN_LEN_DEF = 1;
  localparam int DIGIT_W     = 4;
  localparam int LEN_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/pan_serializer.sv
// Serializes a packed PAN one 4-bit digit per enabled cycle, framed by
// start / pan_end / done pulses, with abort and illegal-length handling.
module pan_serializer
  import pan_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [DIGIT_W*MAX_LEN-1:0] pan_digits,
  input  logic [LEN_W-1:0]           pan_len,
  input  logic                       tx_en,
  input  logic                       abort_req,
  output logic                       start,
  output logic                       digit_valid,
  output logic [DIGIT_W-1:0]         digit_out,
  output logic                       pan_end,
  output logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       len_err
);

  localparam int SHIFT_W = DIGIT_W * MAX_LEN;

  state_t               state, state_d;
  logic [SHIFT_W-1:0]   shreg, shreg_d;
  logic [LEN_W-1:0]     remaining, remaining_d;
  logic                 start_d, digit_valid_d, pan_end_d, abort_d, done_d, len_err_d;
  logic [DIGIT_W-1:0]   digit_out_d;
  logic                 len_ok;

  assign len_ok     = (pan_len >= LEN_W'(MIN_LEN)) && (pan_len <= LEN_W'(MAX_LEN));
  assign busy       = (state != IDLE);
  assign load_ready = (state == IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d       = state;
    shreg_d       = shreg;
    remaining_d   = remaining;
    len_err_d     = len_err;
    start_d       = 1'b0;
    digit_valid_d = 1'b0;
    digit_out_d   = '0;
    pan_end_d     = 1'b0;
    abort_d       = 1'b0;
    done_d        = 1'b0;

    unique case (state)
      IDLE: begin
        if (load_valid) begin
          if (len_ok) begin
            shreg_d     = pan_digits;
            remaining_d = pan_len;
            len_err_d   = 1'b0;
            start_d     = 1'b1;
            state_d     = START;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      START, SEND: begin
        // Abort wins over any digit or done issue on the same edge.
        if (abort_req) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (remaining == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SEND;
          if (tx_en) begin
            digit_valid_d = 1'b1;
            digit_out_d   = shreg[DIGIT_W-1:0];
            pan_end_d     = (remaining == LEN_W'(1));
            shreg_d       = shreg >> DIGIT_W;
            remaining_d   = remaining - LEN_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      remaining   <= '0;
      start       <= 1'b0;
      digit_valid <= 1'b0;
      digit_out   <= '0;
      pan_end     <= 1'b0;
      abort       <= 1'b0;
      done        <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      remaining   <= remaining_d;
      start       <= start_d;
      digit_valid <= digit_valid_d;
      digit_out   <= digit_out_d;
      pan_end     <= pan_end_d;
      abort       <= abort_d;
      done        <= done_d;
      len_err     <= len_err_d;
    end
  end

endmodule

// File: tb/tb_pan_serializer.sv
// Scoreboard bench for pan_serializer: stimulus pushes expected events with
// their cycle stamps, a negedge monitor pops and compares them.
module tb_pan_serializer;
  import pan_pkg::*;

  localparam int ML = 19;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [4*ML-1:0] pan_digits = '0;
  logic [4:0]      pan_len = '0;
  logic            tx_en = 1'b1;
  logic            abort_req = 1'b0;
  logic            start, digit_valid, pan_end, abort, busy, done, len_err;
  logic [3:0]      digit_out;

  pan_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pan_digits (pan_digits),
    .pan_len    (pan_len),
    .tx_en      (tx_en),
    .abort_req  (abort_req),
    .start      (start),
    .digit_valid(digit_valid),
    .digit_out  (digit_out),
    .pan_end    (pan_end),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_START, EV_DIGIT, EV_DONE, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] digit;
    logic       pan_end;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  int p16[16] = '{4, 5, 3, 9, 1, 4, 8, 8, 0, 3, 4, 3, 6, 4, 6, 7};
  int p13[13] = '{10, 11, 12, 13, 14, 15, 1, 2, 3, 4, 5, 6, 7};
  logic [3:0] cur[ML];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(ev_kind_t k, logic [3:0] d, logic pe, int c);
    ev_t e;
    e.kind = k; e.digit = d; e.pan_end = pe; e.cyc = c;
    sb.push_back(e);
  endfunction

  // Monitor: every output pulse must match the head of the scoreboard.
  ev_t mon_e;
  always @(negedge clk) begin
    if (start || digit_valid || done || abort) begin
      check("one_pulse", 64'(int'(start) + int'(digit_valid) + int'(done) + int'(abort)), 64'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got start=%0b dv=%0b done=%0b abort=%0b digit=%0h, expected none (cycle %0d)",
                 start, digit_valid, done, abort, digit_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ev_kind", start ? EV_START : digit_valid ? EV_DIGIT : done ? EV_DONE : EV_ABORT, mon_e.kind);
        check("ev_cycle", cyc, mon_e.cyc);
        check("ev_digit", digit_out, mon_e.kind == EV_DIGIT ? mon_e.digit : 4'h0);
        check("ev_pan_end", pan_end, mon_e.pan_end);
      end
    end else begin
      check("quiet_outputs", {digit_out, pan_end}, 5'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cur(input int len);
    for (int i = 0; i < ML; i++) pan_digits[4*i +: 4] = (i < len) ? cur[i] : 4'hF;
    pan_len = 5'(len);
  endtask

  // Drives one PAN and pushes its expected event stream. gap_after/abort_after/
  // rst_after count digits (1-based); 0 disables the feature.
  task automatic run_pan(input int len, input int gap_after, input int gap_len,
                         input int abort_after, input int rst_after, input bit junk,
                         output int t_load, output int t_end);
    int t, gap_lo, ab_c, rst_c;
    gap_lo = -1; ab_c = -1; rst_c = -1;
    load_cur(len);
    load_valid = 1'b1;
    tx_en      = 1'b1;
    t_load     = cyc;
    push(EV_START, 4'h0, 1'b0, t_load + 1);
    t = t_load + 1;
    for (int i = 1; i <= len; i++) begin
      t++;
      if (gap_after > 0 && i == gap_after + 1) t += gap_len;
      push(EV_DIGIT, cur[i-1], i == len, t);
      if (i == gap_after) gap_lo = t;
      if (i == abort_after) begin
        ab_c = t;
        push(EV_ABORT, 4'h0, 1'b0, t + 1);
        break;
      end
      if (i == rst_after) begin
        rst_c = t;
        break;
      end
    end
    if (ab_c < 0 && rst_c < 0) push(EV_DONE, 4'h0, 1'b0, t + 1);
    t_end = t + 1;
    tick();
    if (!junk) load_valid = 1'b0;
    while (cyc < t_end) begin
      tx_en     = !(gap_lo >= 0 && cyc >= gap_lo && cyc < gap_lo + gap_len);
      abort_req = (cyc == ab_c);
      rst       = (cyc == rst_c);
      if (junk) begin
        pan_digits = {ML{4'h2}};
        pan_len    = 5'd3;
      end
      tick();
    end
    load_valid = 1'b0;
    abort_req  = 1'b0;
    rst        = 1'b0;
    tx_en      = 1'b1;
  endtask

  task automatic bad_load(input int len);
    load_cur(len);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    check("bad_len_err", len_err, 1'b1);
    check("bad_load_ready", load_ready, 1'b1);
    check("bad_busy", busy, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int tl, te;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    tick();

    // Illegal lengths: no start, sticky error, still idle.
    for (int i = 0; i < ML; i++) cur[i] = 4'(i);
    bad_load(0);
    bad_load(20);

    // Contiguous 16-digit PAN.
    for (int i = 0; i < 16; i++) cur[i] = 4'(p16[i]);
    run_pan(16, 0, 0, 0, 0, 1'b0, tl, te);
    @(negedge clk);
    check("t1_done_cycle", cyc - tl, 18);
    check("t1_ready_in_done", load_ready, 1'b0);
    check("t1_len_err_cleared", len_err, 1'b0);
    tick();
    @(negedge clk);
    check("t1_ready_back", load_ready, 1'b1);
    check("t1_ready_cycle", cyc - tl, 19);
    tick();

    // Same PAN with a 3-cycle tx_en gap after digit 5, loads held high meanwhile.
    run_pan(16, 5, 3, 0, 0, 1'b1, tl, te);
    @(negedge clk);
    check("t2_done_cycle", cyc - tl, 21);
    tick();
    tick();

    // 13 digits (values above 9), aborted after digit 6.
    for (int i = 0; i < 13; i++) cur[i] = 4'(p13[i]);
    run_pan(13, 0, 0, 6, 0, 1'b0, tl, te);
    @(negedge clk);
    check("t3_abort_idle", busy, 1'b0);
    tick();
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    @(negedge clk);
    check("t3_idle_abort_ignored", {busy, load_ready}, 2'b01);
    tick();

    // Reset on digit 10, then an immediate 1-digit PAN.
    for (int i = 0; i < 16; i++) cur[i] = 4'(p16[i]);
    run_pan(16, 0, 0, 0, 10, 1'b0, tl, te);
    @(negedge clk);
    check("t4_rst_outputs", {start, digit_valid, digit_out, pan_end, abort, done, len_err, busy},
          11'h0);
    check("t4_rst_ready", load_ready, 1'b1);
    cur[0] = 4'h7;
    run_pan(1, 0, 0, 0, 0, 1'b0, tl, te);
    @(negedge clk);
    check("t5_done_cycle", cyc - tl, 3);
    tick();
    tick();
    tick();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pan_serializer.md
PAN_SERIALIZER -- requirements
Module: pan_serializer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MAX_LEN, 19, largest accepted PAN length in digits.
- MIN_LEN, 1, smallest accepted PAN length in digits.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- load_valid, in, 1, PAN load request.
- load_ready, out, 1, block idle and able to accept a load.
- pan_digits, in, 4*MAX_LEN, packed PAN; digit 0 (first sent) in [3:0].
- pan_len, in, 5, number of digits to send.
- tx_en, in, 1, pacing enable; low inserts gap cycles.
- abort_req, in, 1, cancel the PAN in flight.
- start, out, 1, one-cycle pulse opening a PAN.
- digit_valid, out, 1, digit_out is valid this cycle.
- digit_out, out, 4, current digit.
- pan_end, out, 1, asserted only together with the last digit_valid.
- abort, out, 1, one-cycle pulse when a PAN is cancelled.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse after a PAN is sent completely.
- len_err, out, 1, sticky flag: last load had an illegal pan_len.
REQ-003 The design SHALL use one clock with synchronous, active-high reset, exactly as stated on clk and rst.

Function
REQ-004 The FSM SHALL have states IDLE, START, SEND and DONE; busy = (state != IDLE).
REQ-005 load_ready SHALL equal (state == IDLE); a load SHALL be accepted on an edge where load_valid && load_ready.
REQ-006 On an accepted load with MIN_LEN <= pan_len <= MAX_LEN, the block SHALL capture pan_digits into a shift register and capture pan_len into a remaining-count register, clear len_err, and go to START.
REQ-007 On an accepted load with an illegal pan_len (0, or greater than MAX_LEN), the block SHALL set len_err, stay in IDLE, and drive no start.
REQ-008 start, digit_valid, digit_out, pan_end, abort and done SHALL all be registered outputs.
REQ-009 If a load is accepted at edge T, start SHALL be high for exactly the cycle after T, with digit_valid low in that cycle.
REQ-010 From the START cycle onward, each edge where tx_en = 1 and digits remain SHALL do all of the following:
- present the next digit, with digit_valid = 1, in the following cycle;
- shift the register right by 4;
- decrement the remaining count.
REQ-011 An edge with tx_en = 0 SHALL present digit_valid = 0 in the following cycle and hold the index.
REQ-012 With tx_en tied high, digits SHALL be contiguous; the first digit SHALL appear two cycles after the load edge, and the last digit pan_len+1 cycles after it.
REQ-013 pan_end SHALL be high only in the cycle carrying the last digit; a 1-digit PAN SHALL carry start in one cycle and digit_valid with pan_end in the next.
REQ-014 After the last digit, the FSM SHALL enter DONE and pulse done for one cycle, then return to IDLE; the earliest next start SHALL therefore follow the previous pan_end by at least 3 cycles.
REQ-015 digit_out SHALL pass digit values verbatim, including values above 9; it SHALL be 0 whenever digit_valid = 0.
REQ-016 abort_req sampled high in START or SEND SHALL cause all of the following:
- pulse abort in the next cycle;
- force digit_valid, pan_end and done low;
- return the FSM to IDLE.
REQ-017 abort_req SHALL take priority over a simultaneous final-digit issue; that PAN SHALL produce no pan_end and no done.
REQ-018 abort_req in IDLE or DONE SHALL be ignored.
REQ-019 load_valid outside IDLE SHALL be ignored and SHALL NOT disturb the transfer in progress.

Reset
REQ-020 While rst is sampled high, the FSM SHALL go to IDLE, and the shift register and remaining count SHALL clear to 0.
REQ-021 While rst is sampled high, start, digit_valid, digit_out, pan_end, abort, done and len_err SHALL clear to 0.
REQ-022 A reset mid-PAN SHALL truncate the stream silently, with no abort, pan_end or done pulse.
REQ-023 load_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-024 A shared package pan_pkg SHALL hold:
- the MAX_LEN and MIN_LEN defaults;
- DIGIT_W = 4;
- the PAN length width (5);
- the FSM state enum typedef.
REQ-025 The block SHALL be a single module with no sub-modules; the shift register and counter SHALL be inline.

Verification
REQ-026 Load 16 digits 4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7 at T with tx_en = 1 -> start at T+1; digits in order T+2..T+17; pan_end only at T+17; done at T+18; load_ready back at T+19.
REQ-027 Same 16-digit PAN with tx_en low for 3 cycles after the 5th digit -> 3 digit_valid-low gaps; digit order and count unchanged; pan_end on digit 16 only.
REQ-028 Load pan_len = 0, and separately pan_len = 20 -> len_err = 1, no start, load_ready stays 1.
REQ-029 Load pan_len = 13, assert abort_req after the 6th digit -> abort pulse one cycle later, no further digit_valid, no pan_end, no done, IDLE.
REQ-030 Load pan_len = 1, digit 7 -> start, then a single digit_valid with digit_out = 7 and pan_end = 1 in the same cycle, then done.
REQ-031 Assert rst mid-PAN on the 10th digit -> all outputs 0 next cycle, no pulses, and a new load is accepted right after release.
